// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared encodings for the sequential adder-subtractor
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_seq_if.sv
// rtl/add_sub_seq_if.sv - operand/result handshake bundle for add_sub_seq
interface add_sub_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D_S;
  logic             B_C;
  logic             OVF;
  logic             ZERO;
  logic             NEG;

  modport master (
    output in_valid, A, B, Mode, out_ready,
    input  in_ready, out_valid, D_S, B_C, OVF, ZERO, NEG
  );

  modport slave (
    input  in_valid, A, B, Mode, out_ready,
    output in_ready, out_valid, D_S, B_C, OVF, ZERO, NEG
  );

endinterface

// File: rtl/add_sub_slice.sv
// rtl/add_sub_slice.sv - DIGIT-bit ripple slice, b inverted when subtracting
module add_sub_slice
  import add_sub_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   c;

  assign bx   = b ^ {DIGIT{mode == MODE_SUB}};
  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/add_sub_seq.sv
// rtl/add_sub_seq.sv - digit-serial two's-complement add/sub with valid/ready
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  add_sub_seq_if.slave io
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("add_sub_seq: illegal WIDTH/DIGIT combination");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] ds_q, ds_d;
  logic             bc_q, bc_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [DIGIT-1:0] sl_s;
  logic             sl_cout, sl_cmsb;
  logic [WIDTH-1:0] res_next;
  logic             accept, last;

  add_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh_q[DIGIT-1:0]),
    .b    (b_sh_q[DIGIT-1:0]),
    .cin  (carry_q),
    .mode (mode_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c_msb(sl_cmsb)
  );

  // Partial result enters from the top; its low DIGIT bits would never be read, so they are not stored.
  if (DIGIT == WIDTH) begin : g_one
    assign res_next = sl_s;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] acc_q, acc_d;
    assign res_next = {sl_s, acc_q};
    always_comb begin
      acc_d = acc_q;
      if (state_q == ST_RUN) acc_d = res_next[WIDTH-1:DIGIT];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end
  end

  assign io.in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & io.out_ready);
  assign accept      = io.in_valid & io.in_ready;
  assign last        = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    ds_d    = ds_q;
    bc_d    = bc_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> DIGIT;
      b_sh_d  = b_sh_q >> DIGIT;
      carry_d = sl_cout;
      if (last) begin
        state_d = ST_DONE;
        cnt_d   = '0;
        ds_d    = res_next;
        bc_d    = sl_cout;
        ovf_d   = sl_cmsb ^ sl_cout;
        zero_d  = (res_next == '0);
        neg_d   = res_next[WIDTH-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (accept) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      a_sh_d  = io.A;
      b_sh_d  = io.B;
      mode_d  = io.Mode;
      carry_d = io.Mode;
    end else if (state_q == ST_DONE && io.out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ds_q    <= '0;
      bc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      ds_q    <= ds_d;
      bc_q    <= bc_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign io.out_valid = (state_q == ST_DONE);
  assign io.D_S       = ds_q;
  assign io.B_C       = bc_q;
  assign io.OVF       = ovf_q;
  assign io.ZERO      = zero_q;
  assign io.NEG       = neg_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb/tb_add_sub_seq.sv - scoreboard bench for add_sub_seq in three configurations
module tb_add_sub_seq;
  import add_sub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  add_sub_seq_if #(.WIDTH(8))  m0 ();
  add_sub_seq_if #(.WIDTH(4))  m1 ();
  add_sub_seq_if #(.WIDTH(16)) m2 ();

  add_sub_seq #(.WIDTH(8),  .DIGIT(2)) dut0 (.clk(clk), .rst(rst), .io(m0.slave));
  add_sub_seq #(.WIDTH(4),  .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .io(m1.slave));
  add_sub_seq #(.WIDTH(16), .DIGIT(1)) dut2 (.clk(clk), .rst(rst), .io(m2.slave));

  typedef struct {
    logic [15:0] ds;
    logic        bc;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  bit lat0 = 0, lat1 = 0, lat2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] ds, input logic bc, input logic ovf,
                              input int w, input int acc);
    exp_t e;
    e.ds   = ds;
    e.bc   = bc;
    e.ovf  = ovf;
    e.zero = (ds == 16'h0);
    e.neg  = ds[w-1];
    e.acc  = acc;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input logic [15:0] ds,
                         input logic bc, input logic ovf, input logic zero, input logic neg);
    chk({tag, ".D_S"},  32'(ds),   32'(e.ds));
    chk({tag, ".B_C"},  32'(bc),   32'(e.bc));
    chk({tag, ".OVF"},  32'(ovf),  32'(e.ovf));
    chk({tag, ".ZERO"}, 32'(zero), 32'(e.zero));
    chk({tag, ".NEG"},  32'(neg),  32'(e.neg));
  endtask

  // Monitors: every cycle with out_valid is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && m0.out_valid) begin
      chk("dut8.out_valid_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        if (!lat0) begin chk("dut8.latency", 32'(cyc - q0[0].acc), 32'd4); lat0 = 1; end
        cmp_out("dut8", q0[0], 16'(m0.D_S), m0.B_C, m0.OVF, m0.ZERO, m0.NEG);
        chk("dut8.in_ready_in_done", 32'(m0.in_ready), 32'(m0.out_ready));
        if (m0.out_ready) begin void'(q0.pop_front()); lat0 = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m1.out_valid) begin
      chk("dut4.out_valid_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        if (!lat1) begin chk("dut4.latency", 32'(cyc - q1[0].acc), 32'd1); lat1 = 1; end
        cmp_out("dut4", q1[0], 16'(m1.D_S), m1.B_C, m1.OVF, m1.ZERO, m1.NEG);
        if (m1.out_ready) begin void'(q1.pop_front()); lat1 = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m2.out_valid) begin
      chk("dut16.out_valid_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        if (!lat2) begin chk("dut16.latency", 32'(cyc - q2[0].acc), 32'd16); lat2 = 1; end
        cmp_out("dut16", q2[0], m2.D_S, m2.B_C, m2.OVF, m2.ZERO, m2.NEG);
        if (m2.out_ready) begin void'(q2.pop_front()); lat2 = 0; end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input logic md,
                       input logic [15:0] ds, input logic bc, input logic ovf, input bit push);
    logic rdy;
    bit   ok;
    ok = 0;
    case (d)
      0: begin m0.A = a[7:0]; m0.B = b[7:0]; m0.Mode = md; m0.in_valid = 1'b1; end
      1: begin m1.A = a[3:0]; m1.B = b[3:0]; m1.Mode = md; m1.in_valid = 1'b1; end
      default: begin m2.A = a; m2.B = b; m2.Mode = md; m2.in_valid = 1'b1; end
    endcase
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rdy = (d == 0) ? m0.in_ready : (d == 1) ? m1.in_ready : m2.in_ready;
      if (rdy) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    chk("issue.accept_in_time", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    m0.in_valid = 1'b0;
    m1.in_valid = 1'b0;
    m2.in_valid = 1'b0;
    if (push && ok) begin
      case (d)
        0: q0.push_back(mk(ds, bc, ovf, 8, cyc));
        1: q1.push_back(mk(ds, bc, ovf, 4, cyc));
        default: q2.push_back(mk(ds, bc, ovf, 16, cyc));
      endcase
    end
  endtask

  task automatic drain(input int d);
    int n;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      if (n == 0) break;
    end
    chk("drain.queue_empty", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m0.in_valid = 0; m0.A = '0; m0.B = '0; m0.Mode = 0; m0.out_ready = 1;
    m1.in_valid = 0; m1.A = '0; m1.B = '0; m1.Mode = 0; m1.out_ready = 1;
    m2.in_valid = 0; m2.A = '0; m2.B = '0; m2.Mode = 0; m2.out_ready = 1;

    #12;
    chk("reset.in_ready",  32'(m0.in_ready),  32'd1);
    chk("reset.out_valid", 32'(m0.out_valid), 32'd0);
    chk("reset.D_S",       32'(m0.D_S),       32'd0);
    chk("reset.B_C",       32'(m0.B_C),       32'd0);
    chk("reset.OVF",       32'(m0.OVF),       32'd0);
    chk("reset.ZERO",      32'(m0.ZERO),      32'd0);
    chk("reset.NEG",       32'(m0.NEG),       32'd0);
    chk("reset.dut4_in_ready",  32'(m1.in_ready), 32'd1);
    chk("reset.dut16_in_ready", 32'(m2.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 16'hC8, 16'h64, MODE_ADD, 16'h2C, 1'b1, 1'b0, 1);
    drain(0);

    issue(0, 16'h05, 16'h03, MODE_SUB, 16'h02, 1'b1, 1'b0, 1);
    issue(0, 16'h03, 16'h05, MODE_SUB, 16'hFE, 1'b0, 1'b0, 1);
    issue(0, 16'h0F, 16'h0F, MODE_SUB, 16'h00, 1'b1, 1'b0, 1);
    issue(0, 16'h7F, 16'h01, MODE_ADD, 16'h80, 1'b0, 1'b1, 1);
    issue(0, 16'h80, 16'h01, MODE_SUB, 16'h7F, 1'b1, 1'b1, 1);
    drain(0);

    // Backpressure, then release together with a new operand set.
    issue(0, 16'h40, 16'h40, MODE_ADD, 16'h80, 1'b0, 1'b1, 1);
    m0.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m0.out_valid) break;
    end
    chk("bp.out_valid_seen", 32'(m0.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp.in_ready_low", 32'(m0.in_ready), 32'd0);
    @(posedge clk); #1;
    m0.out_ready = 1'b1;
    issue(0, 16'h10, 16'h20, MODE_ADD, 16'h30, 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("b2b.out_valid_low", 32'(m0.out_valid), 32'd0);
    @(posedge clk); #1;
    drain(0);

    // Abort mid-operation.
    issue(0, 16'h11, 16'h22, MODE_ADD, 16'h33, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.in_ready",  32'(m0.in_ready),  32'd1);
    chk("abort.out_valid", 32'(m0.out_valid), 32'd0);
    chk("abort.D_S",       32'(m0.D_S),       32'd0);
    chk("abort.ZERO",      32'(m0.ZERO),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort.no_out_valid", 32'(m0.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(0, 16'hFF, 16'h01, MODE_ADD, 16'h00, 1'b1, 1'b0, 1);
    drain(0);

    issue(1, 16'hF, 16'h1, MODE_ADD, 16'h0, 1'b1, 1'b0, 1);
    drain(1);
    issue(1, 16'h7, 16'h1, MODE_ADD, 16'h8, 1'b0, 1'b1, 1);
    drain(1);
    issue(2, 16'h8000, 16'h0001, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, 1);
    issue(2, 16'h1234, 16'h4321, MODE_ADD, 16'h5555, 1'b0, 1'b0, 1);
    drain(2);

    chk("end.q0_empty", 32'(q0.size()), 32'd0);
    chk("end.q1_empty", 32'(q1.size()), 32'd0);
    chk("end.q2_empty", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
